// File: rtl/seg_code_sender_if.sv
// rtl/seg_code_sender_if.sv - code handshake bundle between a producer and seg_code_sender.
// Optional inj sideband exists only when PARITY_INJECT_EN is defined.
interface seg_code_sender_if;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_ready;
`ifdef PARITY_INJECT_EN
    logic       inj;

    modport master (output in_valid, output in_data, output inj, input in_ready);
    modport slave  (input in_valid, input in_data, input inj, output in_ready);
`else
    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
`endif
endinterface

// File: rtl/seg_code_sender.sv
// rtl/seg_code_sender.sv - 5-bit code + parity word source with hold timer and one-entry pending buffer.
// Optional feature macro: PARITY_INJECT_EN (per-word parity inversion via inj).
module seg_code_sender #(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CODE    = 23
) (
    input  logic            clk,
    input  logic            rst,
    seg_code_sender_if.slave in_if,
    output logic            b1,
    output logic            b2,
    output logic            b3,
    output logic            b4,
    output logic            b5,
    output logic            b_par,
    output logic            busy,
    output logic            sent,
    output logic            err
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       pend_full;
    logic [4:0] pend_code;
    logic       pend_inj;

    logic       xfer;
    logic       legal;
    logic       take;
    logic       in_inj;

`ifdef PARITY_INJECT_EN
    assign in_inj = in_if.inj;
`else
    assign in_inj = 1'b0;
`endif

    assign in_if.in_ready = ~rst & ~pend_full;
    assign xfer  = in_if.in_valid & in_if.in_ready;
    assign legal = (int'(in_if.in_data) <= MAX_CODE);
    assign take  = xfer & legal;

    // Word layout is {b1..b5, b_par}; inj flips only the parity bit.
    function automatic logic [5:0] word_of(input logic [4:0] code, input logic inv);
        return {code, (^code) ^ inv};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            pend_full <= 1'b0;
            pend_code <= 5'd0;
            pend_inj  <= 1'b0;
            {b1, b2, b3, b4, b5, b_par} <= 6'd0;
            busy      <= 1'b0;
            sent      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err  <= xfer & ~legal;
            sent <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        {b1, b2, b3, b4, b5, b_par} <= word_of(in_if.in_data, in_inj);
                        state <= HOLD;
                        busy  <= 1'b1;
                        cnt   <= RELOAD;
                        sent  <= (RELOAD == 8'd0);
                    end
                end
                HOLD: begin
                    if (cnt != 8'd0) begin
                        cnt  <= cnt - 8'd1;
                        sent <= (cnt == 8'd1);
                        // in_ready guarantees the buffer is empty here
                        if (take) begin
                            pend_full <= 1'b1;
                            pend_code <= in_if.in_data;
                            pend_inj  <= in_inj;
                        end
                    end else if (pend_full) begin
                        {b1, b2, b3, b4, b5, b_par} <= word_of(pend_code, pend_inj);
                        pend_full <= 1'b0;
                        cnt       <= RELOAD;
                        sent      <= (RELOAD == 8'd0);
                    end else if (take) begin
                        {b1, b2, b3, b4, b5, b_par} <= word_of(in_if.in_data, in_inj);
                        cnt  <= RELOAD;
                        sent <= (RELOAD == 8'd0);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_code_sender.sv
// tb/tb_seg_code_sender.sv - scoreboard bench for seg_code_sender (directed vectors).
module tb_seg_code_sender;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_code_sender_if bus ();
    logic b1, b2, b3, b4, b5, b_par, busy, sent, err;

`ifdef PARITY_INJECT_EN
    logic inj_drive = 1'b0;
    assign bus.inj = inj_drive;
`endif

    seg_code_sender #(.HOLD_CYCLES(HOLD), .MAX_CODE(23)) dut (
        .clk   (clk),
        .rst   (rst),
        .in_if (bus),
        .b1    (b1),
        .b2    (b2),
        .b3    (b3),
        .b4    (b4),
        .b5    (b5),
        .b_par (b_par),
        .busy  (busy),
        .sent  (sent),
        .err   (err)
    );

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];
    int err_exp  = 0;
    int hold_cnt = 0;

    function automatic logic [5:0] word();
        return {b1, b2, b3, b4, b5, b_par};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected word at each sent pulse and checks hold length.
    always @(negedge clk) begin
        if (rst) begin
            hold_cnt = 0;
        end else begin
            if (busy) hold_cnt++;
            else hold_cnt = 0;
            if (sent) begin
                check("sent_busy", 32'(busy), 32'd1);
                check("hold_len", 32'(hold_cnt), 32'(HOLD));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sent: got word %b expected none", word());
                end else begin
                    check("sb_word", 32'(word()), 32'(exp_q.pop_front()));
                end
                hold_cnt = 0;
            end
            if (err) begin
                check("sb_err_expected", 32'(err_exp > 0), 32'd1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    task automatic send(input logic [4:0] code, input logic [5:0] exp_w, input bit is_legal);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = code;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (code %0d)", code);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (is_legal) exp_q.push_back(exp_w);
        else err_exp++;
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 5'd0;

        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_word", 32'(word()), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_sent", 32'(sent), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 13 = 01101, parity 1
        @(posedge clk);
        #1;
        send(5'd13, 6'b01101_1, 1'b1);
        check("c13_word", 32'(word()), 32'h1B);
        check("c13_busy", 32'(busy), 32'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("c13_held", 32'(word()), 32'h1B);
        check("c13_idle_busy", 32'(busy), 32'd0);

        // 5 = 00101/0 then 22 = 10110/1 back to back
        send(5'd5, 6'b00101_0, 1'b1);
        send(5'd22, 6'b10110_1, 1'b1);
        @(negedge clk);
        check("pend_ready_low", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("b2b_busy_len", 32'(n), 32'(2 * HOLD - 1));
        check("b2b_final_word", 32'(word()), 32'h2D);

        // out-of-range codes in IDLE
        send(5'd24, 6'd0, 1'b0);
        @(negedge clk);
        check("e24_err", 32'(err), 32'd1);
        check("e24_busy", 32'(busy), 32'd0);
        check("e24_word", 32'(word()), 32'h2D);
        check("e24_ready", 32'(bus.in_ready), 32'd1);
        send(5'd31, 6'd0, 1'b0);
        @(negedge clk);
        check("e31_err", 32'(err), 32'd1);
        check("e31_word", 32'(word()), 32'h2D);
        @(negedge clk);
        check("err_one_cycle", 32'(err), 32'd0);

        // transfer on the sent cycle with an empty buffer loads directly
        send(5'd2, 6'b00010_1, 1'b1);
        n = 0;
        while (!sent && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("direct_saw_sent", 32'(sent), 32'd1);
        send(5'd4, 6'b00100_1, 1'b1);
        check("direct_busy", 32'(busy), 32'd1);
        check("direct_word", 32'(word()), 32'h09);
        wait_idle();

        // reset mid-hold with a pending word
        send(5'd3, 6'b00011_0, 1'b1);
        send(5'd9, 6'b01001_0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_word", 32'(word()), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_word", 32'(word()), 32'd0);
        send(5'd17, 6'b10001_0, 1'b1);
        check("post_rst_load", 32'(word()), 32'h22);
        wait_idle();

`ifdef PARITY_INJECT_EN
        inj_drive = 1'b1;
        send(5'd7, 6'b00111_0, 1'b1);
        check("inj_word", 32'(word()), 32'h0E);
        inj_drive = 1'b0;
        send(5'd7, 6'b00111_1, 1'b1);
        wait_idle();
        check("noinj_word", 32'(word()), 32'h0F);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("err_drained", 32'(err_exp), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
